// File: rtl/inst_mem_loadable_if.sv
// Fetch and loader bus for inst_mem_loadable.
// master: the fetch stage plus the host loader. slave: the memory.
interface inst_mem_loadable_if #(
    parameter int ADDR_W = 8,
    parameter int INST_W = 16
);
    // fetch side
    logic [ADDR_W-1:0] addr;
    logic              fetch_en;
    logic [INST_W-1:0] instruction;
    logic              inst_valid;
    // loader side
    logic              load_mode;
    logic              ld_valid;
    logic [7:0]        ld_byte;
    logic              ld_ready;
    logic [ADDR_W:0]   ld_words;
    logic              ld_err;

    modport master (
        output addr, fetch_en, load_mode, ld_valid, ld_byte,
        input  instruction, inst_valid, ld_ready, ld_words, ld_err
    );

    modport slave (
        input  addr, fetch_en, load_mode, ld_valid, ld_byte,
        output instruction, inst_valid, ld_ready, ld_words, ld_err
    );
endinterface

// File: rtl/inst_mem_loadable.sv
// Instruction memory for the 16-bit CPU with a registered 1-cycle fetch
// and a byte-stream loader that writes programs at run time.
// While load_mode is held high the CPU sees HALT_WORD with inst_valid low.
// Bytes arrive MSB-first; a word is written once all of its bytes are in.
// Build option: define BOOT_ROM_EN to preload the boot program; otherwise
// every word powers up as HALT_WORD. The loader is the same in both builds.
module inst_mem_loadable #(
    parameter int                ADDR_W    = 8,
    parameter int                INST_W    = 16,
    parameter int                DEPTH     = 256,
    parameter logic [INST_W-1:0] HALT_WORD = INST_W'(16'hF000)
) (
    input logic clk,
    input logic rst,
    inst_mem_loadable_if.slave bus
);
    localparam int BYTES = INST_W / 8;
    localparam int BI_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
`ifdef BOOT_ROM_EN
    // Storage is padded to hold the whole boot image even for tiny DEPTH;
    // words at or beyond DEPTH are never readable or writable.
    localparam int MEM_N = (DEPTH < 10) ? 10 : DEPTH;
`else
    localparam int MEM_N = DEPTH;
`endif
    localparam int MI_W = (MEM_N > 1) ? $clog2(MEM_N) : 1;

    localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W + 1)'(DEPTH);
    localparam logic [BI_W-1:0] LAST_BYTE = BI_W'(BYTES - 1);

    typedef enum logic {RUN, LOAD} state_t;

    // Contents survive reset; only the power-up image differs per build.
`ifdef BOOT_ROM_EN
    logic [INST_W-1:0] mem [0:MEM_N-1] = '{
        0: INST_W'(16'h8442), 1: INST_W'(0), 2: INST_W'(0), 3: INST_W'(0),
        4: INST_W'(16'h88F5), 5: INST_W'(0), 6: INST_W'(0), 7: INST_W'(0),
        8: INST_W'(16'hA600), 9: INST_W'(16'hF000),
        default: HALT_WORD
    };
`else
    logic [INST_W-1:0] mem [0:MEM_N-1] = '{default: HALT_WORD};
`endif

    state_t            state, next_state;
    logic [INST_W-1:0] instr_q;
    logic              vld_q;
    logic [BI_W-1:0]   idx;
    logic [ADDR_W:0]   wr_ptr;   // doubles as the words-written count
    logic              err_q;
    logic [INST_W-1:0] asm_q;    // holds the most recent bytes of the word
    logic [INST_W-1:0] wr_word;
    logic              ld_ready, accept, full, last, wr_en;
    logic              enter_load, exit_load, in_range;

    // Next state plus loader/fetch decode.
    always_comb begin
        next_state = state;
        ld_ready   = 1'b0;
        enter_load = 1'b0;
        exit_load  = 1'b0;
        unique case (state)
            RUN: begin
                if (bus.load_mode) begin
                    next_state = LOAD;
                    enter_load = 1'b1;
                end
            end
            LOAD: begin
                // Ready comes from state alone, so the byte offered in the
                // same cycle load_mode drops is still taken.
                ld_ready = 1'b1;
                if (!bus.load_mode) begin
                    next_state = RUN;
                    exit_load  = 1'b1;
                end
            end
            default: next_state = RUN;
        endcase
        accept   = ld_ready && bus.ld_valid;
        full     = (wr_ptr == DEPTH_L);
        last     = (idx == LAST_BYTE);
        wr_en    = accept && !full && last && !rst;
        wr_word  = INST_W'({asm_q, bus.ld_byte});
        in_range = ({1'b0, bus.addr} < DEPTH_L);
    end

    // State, fetch register and loader bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RUN;
            instr_q <= HALT_WORD;
            vld_q   <= 1'b0;
            idx     <= '0;
            wr_ptr  <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= next_state;

            if (state == LOAD) begin
                instr_q <= HALT_WORD;
                vld_q   <= 1'b0;
            end else if (bus.fetch_en) begin
                instr_q <= in_range ? mem[MI_W'(bus.addr)] : HALT_WORD;
                vld_q   <= 1'b1;
            end else begin
                vld_q   <= 1'b0;
            end

            if (enter_load) begin
                idx    <= '0;
                wr_ptr <= '0;
                err_q  <= 1'b0;
            end else if (accept) begin
                if (full) begin
                    err_q <= 1'b1;
                end else if (last) begin
                    idx    <= '0;
                    wr_ptr <= wr_ptr + 1'b1;
                end else begin
                    idx <= idx + 1'b1;
                end
            end

            // Leaving LOAD throws away any partly assembled word.
            if (exit_load) idx <= '0;
        end
    end

    // Byte assembly shift register; older bytes simply fall off the top.
    always_ff @(posedge clk) begin
        if (accept && !full) asm_q <= wr_word;
    end

    // Memory write port; suppressed during reset so a mid-load reset drops the word.
    always_ff @(posedge clk) begin
        if (wr_en) mem[MI_W'(wr_ptr)] <= wr_word;
    end

    assign bus.instruction = instr_q;
    assign bus.inst_valid  = vld_q;
    assign bus.ld_ready    = ld_ready;
    assign bus.ld_words    = wr_ptr;
    assign bus.ld_err      = err_q;
endmodule

// File: tb/tb_inst_mem_loadable.sv
// Directed bench for inst_mem_loadable: three instances (DEPTH 256, 4, 200)
// sharing clock and reset. Inputs change and outputs are sampled on negedge.
module tb_inst_mem_loadable;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    localparam logic [15:0] HALT = 16'hF000;
`ifdef BOOT_ROM_EN
    localparam logic [15:0] B0 = 16'h8442;
    localparam logic [15:0] B4 = 16'h88F5;
    localparam logic [15:0] B8 = 16'hA600;
`else
    localparam logic [15:0] B0 = 16'hF000;
    localparam logic [15:0] B4 = 16'hF000;
    localparam logic [15:0] B8 = 16'hF000;
`endif

    inst_mem_loadable_if #(.ADDR_W(8), .INST_W(16)) m_if ();
    inst_mem_loadable_if #(.ADDR_W(8), .INST_W(16)) s4_if ();
    inst_mem_loadable_if #(.ADDR_W(8), .INST_W(16)) s200_if ();

    inst_mem_loadable #(.ADDR_W(8), .INST_W(16), .DEPTH(256)) dut (
        .clk(clk), .rst(rst), .bus(m_if));
    inst_mem_loadable #(.ADDR_W(8), .INST_W(16), .DEPTH(4)) dut4 (
        .clk(clk), .rst(rst), .bus(s4_if));
    inst_mem_loadable #(.ADDR_W(8), .INST_W(16), .DEPTH(200)) dut200 (
        .clk(clk), .rst(rst), .bus(s200_if));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        m_if.addr = '0;    m_if.fetch_en = 0;    m_if.load_mode = 0;    m_if.ld_valid = 0;    m_if.ld_byte = '0;
        s4_if.addr = '0;   s4_if.fetch_en = 0;   s4_if.load_mode = 0;   s4_if.ld_valid = 0;   s4_if.ld_byte = '0;
        s200_if.addr = '0; s200_if.fetch_en = 0; s200_if.load_mode = 0; s200_if.ld_valid = 0; s200_if.ld_byte = '0;
        tick();
        tick();

        // reset state
        check("rst_instr", m_if.instruction, HALT);
        check("rst_valid", m_if.inst_valid, 0);
        check("rst_ready", m_if.ld_ready, 0);
        check("rst_words", m_if.ld_words, 0);
        check("rst_err", m_if.ld_err, 0);
        check("rst_ready4", s4_if.ld_ready, 0);
        rst = 1'b0;

        // 1: boot image (or HALT fill) fetch
        m_if.fetch_en = 1; m_if.addr = 8'd0; tick();
        check("boot_a0", m_if.instruction, B0);
        check("boot_v0", m_if.inst_valid, 1);
        m_if.addr = 8'd4; tick();
        check("boot_a4", m_if.instruction, B4);
        m_if.addr = 8'd8; tick();
        check("boot_a8", m_if.instruction, B8);
        m_if.addr = 8'd9; tick();
        check("boot_a9", m_if.instruction, HALT);
        check("boot_v9", m_if.inst_valid, 1);
        m_if.fetch_en = 0; tick();
        check("idle_valid", m_if.inst_valid, 0);

        // 2: load two words, last byte offered as load_mode falls
        m_if.load_mode = 1; tick();
        check("ld2_ready", m_if.ld_ready, 1);
        m_if.ld_valid = 1; m_if.ld_byte = 8'h84; tick();
        check("ld2_instr", m_if.instruction, HALT);
        check("ld2_valid", m_if.inst_valid, 0);
        m_if.ld_byte = 8'h42; tick();
        check("ld2_words1", m_if.ld_words, 1);
        m_if.ld_byte = 8'hF0; tick();
        m_if.ld_byte = 8'h00; m_if.load_mode = 0; tick();
        m_if.ld_valid = 0;
        check("ld2_words2", m_if.ld_words, 2);
        check("ld2_ready0", m_if.ld_ready, 0);
        m_if.fetch_en = 1; m_if.addr = 8'd0; tick();
        check("ld2_w0", m_if.instruction, 16'h8442);
        check("ld2_v0", m_if.inst_valid, 1);
        m_if.addr = 8'd1; tick();
        check("ld2_w1", m_if.instruction, 16'hF000);
        m_if.fetch_en = 0;

        // 3: partial trailing word discarded
        m_if.load_mode = 1; tick();
        check("ld3_clr", m_if.ld_words, 0);
        m_if.ld_valid = 1; m_if.ld_byte = 8'h12; tick();
        m_if.ld_byte = 8'h34; tick();
        m_if.ld_byte = 8'h56; tick();
        m_if.ld_valid = 0; m_if.load_mode = 0; tick();
        check("ld3_words", m_if.ld_words, 1);
        m_if.fetch_en = 1; m_if.addr = 8'd0; tick();
        check("ld3_w0", m_if.instruction, 16'h1234);
        m_if.addr = 8'd1; tick();
        check("ld3_w1", m_if.instruction, 16'hF000);
        m_if.fetch_en = 0;

        // 4: DEPTH=4 overflow
        s4_if.load_mode = 1; tick();
        s4_if.ld_valid = 1;
        for (int b = 1; b <= 10; b++) begin
            s4_if.ld_byte = 8'(b);
            tick();
            if (b == 8) begin
                check("ov_words8", s4_if.ld_words, 4);
                check("ov_err8", s4_if.ld_err, 0);
            end
            if (b == 9) check("ov_err9", s4_if.ld_err, 1);
        end
        check("ov_words10", s4_if.ld_words, 4);
        check("ov_err10", s4_if.ld_err, 1);
        s4_if.ld_valid = 0; s4_if.load_mode = 0; tick();
        s4_if.fetch_en = 1;
        for (int i = 0; i < 4; i++) begin
            s4_if.addr = 8'(i); tick();
            check("ov_mem", s4_if.instruction, {8'(2*i+1), 8'(2*i+2)});
        end
        s4_if.addr = 8'd4; tick();
        check("ov_oor", s4_if.instruction, HALT);
        s4_if.fetch_en = 0;
        s4_if.load_mode = 1; tick();
        check("ov_errclr", s4_if.ld_err, 0);
        check("ov_wordclr", s4_if.ld_words, 0);
        s4_if.load_mode = 0; tick();

        // 5: DEPTH=200 range edge and hold
        s200_if.load_mode = 1; tick();
        s200_if.ld_valid = 1; s200_if.ld_byte = 8'hAB; tick();
        s200_if.ld_byte = 8'hCD; tick();
        s200_if.ld_valid = 0; s200_if.load_mode = 0; tick();
        s200_if.fetch_en = 1; s200_if.addr = 8'd0; tick();
        check("r_w0", s200_if.instruction, 16'hABCD);
        s200_if.addr = 8'd199; tick();
        check("r_199", s200_if.instruction, HALT);
        s200_if.addr = 8'd0; tick();
        s200_if.addr = 8'd200; tick();
        check("r_200", s200_if.instruction, HALT);
        s200_if.addr = 8'd250; tick();
        check("r_250", s200_if.instruction, HALT);
        check("r_250v", s200_if.inst_valid, 1);
        s200_if.addr = 8'd0; tick();
        s200_if.fetch_en = 0; s200_if.addr = 8'd250; tick();
        check("r_holdv", s200_if.inst_valid, 0);
        check("r_hold", s200_if.instruction, 16'hABCD);

        // 6: reset in the middle of a word
        m_if.load_mode = 1; tick();
        m_if.ld_valid = 1; m_if.ld_byte = 8'hAA; tick();
        m_if.ld_byte = 8'hBB; tick();
        m_if.ld_byte = 8'h77; tick();
        rst = 1; m_if.ld_valid = 0; m_if.load_mode = 0; tick();
        check("mr_ready", m_if.ld_ready, 0);
        check("mr_valid", m_if.inst_valid, 0);
        check("mr_instr", m_if.instruction, HALT);
        check("mr_words", m_if.ld_words, 0);
        rst = 0;
        m_if.fetch_en = 1; m_if.addr = 8'd0; tick();
        check("mr_w0", m_if.instruction, 16'hAABB);
        m_if.addr = 8'd1; tick();
        check("mr_w1", m_if.instruction, 16'hF000);
        m_if.fetch_en = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
